// File: rtl/stepper_phase_decoder_pkg.sv
// Shared definitions for the stepper coil decoder and the motor driver:
// phase codes, coil patterns, position width and the transition rules.
package stepper_pkg;

  localparam int POS_W = 14;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_P1   = 3'd1,
    PH_P2   = 3'd2,
    PH_P3   = 3'd3,
    PH_P4   = 3'd4,
    PH_BAD  = 3'd7
  } phase_e;

  // Coil patterns, ordered {A1,B1,A2,B2}
  localparam logic [3:0] PAT_IDLE = 4'b0000;
  localparam logic [3:0] PAT_P1   = 4'b1100;
  localparam logic [3:0] PAT_P2   = 4'b0110;
  localparam logic [3:0] PAT_P3   = 4'b0011;
  localparam logic [3:0] PAT_P4   = 4'b1001;

  typedef enum logic [1:0] {
    TR_NONE = 2'd0,
    TR_FWD  = 2'd1,
    TR_REV  = 2'd2,
    TR_ERR  = 2'd3
  } trans_e;

  function automatic phase_e decode_pattern(input logic [3:0] pat);
    phase_e ph;
    case (pat)
      PAT_IDLE: ph = PH_IDLE;
      PAT_P1:   ph = PH_P1;
      PAT_P2:   ph = PH_P2;
      PAT_P3:   ph = PH_P3;
      PAT_P4:   ph = PH_P4;
      default:  ph = PH_BAD;
    endcase
    return ph;
  endfunction

  // P4 has code 4, so its low two bits are 0 and the ring P1..P4 becomes
  // a plain mod-4 difference: +1 forward, -1 reverse, 2 is a skipped phase.
  function automatic trans_e classify(input phase_e from_ph, input phase_e to_ph);
    logic [2:0] f;
    logic [2:0] t;
    logic [1:0] d;
    trans_e     r;
    f = from_ph;
    t = to_ph;
    d = t[1:0] - f[1:0];
    r = TR_ERR;
    if (from_ph == PH_BAD || to_ph == PH_BAD) r = TR_ERR;
    else if (to_ph == PH_IDLE) r = TR_NONE;
    else if (from_ph == PH_IDLE) r = (to_ph == PH_P1 || to_ph == PH_P4) ? TR_NONE : TR_ERR;
    else if (d == 2'd1) r = TR_FWD;
    else if (d == 2'd3) r = TR_REV;
    return r;
  endfunction

endpackage

// File: rtl/stepper_phase_decoder_if.sv
// Coil inputs, control strobes and status outputs of the phase decoder.
interface stepper_phase_decoder_if;
  import stepper_pkg::*;

  logic                    A1;
  logic                    B1;
  logic                    A2;
  logic                    B2;
  logic                    clear;
  logic                    clear_err;
  logic signed [POS_W-1:0] position;
  logic                    dir;
  logic                    moving;
  logic                    step_pulse;
  logic                    err;
  logic [2:0]              phase;

  modport master (
    output A1, B1, A2, B2, clear, clear_err,
    input  position, dir, moving, step_pulse, err, phase
  );

  modport slave (
    input  A1, B1, A2, B2, clear, clear_err,
    output position, dir, moving, step_pulse, err, phase
  );

endinterface

// File: rtl/stepper_phase_decoder_phase_filter.sv
// Synchronizes the raw coil pattern and accepts a new pattern only after it
// has been stable for FILT_CYCLES consecutive clocks.
module phase_filter
  import stepper_pkg::*;
#(
  parameter int FILT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] pat_async,
  output logic [3:0] accepted,
  output logic       accept_stb
);

  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] prev_pat;
  logic [7:0] run_cnt;
  logic [7:0] run_next;
  logic       hit;

  // two-flop synchronizer on every coil line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= pat_async;
      sync2 <= sync1;
    end
  end

  // run length including this sample; saturates so it can never wrap
  always_comb begin
    run_next = 8'd1;
    hit      = 1'b0;
    if (sync2 == prev_pat && run_cnt != 8'd0)
      run_next = (run_cnt == 8'hFF) ? 8'hFF : run_cnt + 8'd1;
    hit = (sync2 != accepted) && (run_next >= 8'(FILT_CYCLES));
  end

  // stability counter and accepted-pattern register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_pat   <= PAT_IDLE;
      run_cnt    <= '0;
      accepted   <= PAT_IDLE;
      accept_stb <= 1'b0;
    end else begin
      accept_stb <= 1'b0;
      prev_pat   <= sync2;
      if (sync2 == accepted) begin
        run_cnt <= '0;
      end else if (hit) begin
        accepted   <= sync2;
        accept_stb <= 1'b1;
        run_cnt    <= '0;
      end else begin
        run_cnt <= run_next;
      end
    end
  end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Decodes filtered stepper coil patterns into a signed position count,
// direction, motion status and a sticky illegal-sequence flag.
module stepper_phase_decoder
  import stepper_pkg::*;
#(
  parameter int FILT_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input logic                    clk,
  input logic                    reset,
  stepper_phase_decoder_if.slave bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [3:0]              coil_pat;
  logic [3:0]              acc_pat;
  logic                    acc_stb;
  phase_e                  last_ph;
  trans_e                  dec_kind;
  logic                    dec_vld;
  logic                    count_now;
  phase_e                  phase_q;
  logic signed [POS_W-1:0] pos_q;
  logic                    dir_q;
  logic                    step_q;
  logic                    err_q;
  logic                    moving_q;
  logic [TMO_W-1:0]        tmo_cnt;

  assign coil_pat = {bus.A1, bus.B1, bus.A2, bus.B2};

  phase_filter #(
    .FILT_CYCLES(FILT_CYCLES)
  ) u_filter (
    .clk       (clk),
    .reset     (reset),
    .pat_async (coil_pat),
    .accepted  (acc_pat),
    .accept_stb(acc_stb)
  );

  // classify each newly accepted pattern against the previously accepted one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_ph  <= PH_IDLE;
      dec_kind <= TR_NONE;
      dec_vld  <= 1'b0;
    end else begin
      dec_vld <= acc_stb;
      if (acc_stb) begin
        last_ph  <= decode_pattern(acc_pat);
        dec_kind <= classify(last_ph, decode_pattern(acc_pat));
      end
    end
  end

  // clear suppresses the count but the new phase is still taken
  assign count_now = dec_vld && (dec_kind == TR_FWD || dec_kind == TR_REV) && !bus.clear;

  // position, direction, phase, step pulse and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= PH_IDLE;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q <= count_now;
      if (dec_vld) phase_q <= last_ph;
      if (bus.clear) pos_q <= '0;
      else if (count_now) pos_q <= (dec_kind == TR_FWD) ? pos_q + POS_ONE : pos_q - POS_ONE;
      if (count_now) dir_q <= (dec_kind == TR_FWD);
      if (dec_vld && dec_kind == TR_ERR) err_q <= 1'b1;
      else if (bus.clear || bus.clear_err) err_q <= 1'b0;
    end
  end

  // motion timeout: down-counter reloaded on every count, stops at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt  <= '0;
      moving_q <= 1'b0;
    end else if (count_now) begin
      tmo_cnt  <= TMO_LOAD;
      moving_q <= 1'b1;
    end else if (tmo_cnt != '0) begin
      tmo_cnt  <= tmo_cnt - TMO_ONE;
      moving_q <= (tmo_cnt != TMO_ONE);
    end
  end

  assign bus.position   = pos_q;
  assign bus.dir        = dir_q;
  assign bus.moving     = moving_q;
  assign bus.step_pulse = step_q;
  assign bus.err        = err_q;
  assign bus.phase      = phase_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: a sample-window model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_stepper_phase_decoder;
  import stepper_pkg::*;

  localparam int FILT = 16;
  localparam int TMO  = 200;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stepper_phase_decoder_if bus ();
  stepper_phase_decoder_if bus2 ();

  stepper_phase_decoder #(.FILT_CYCLES(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  stepper_phase_decoder #(.FILT_CYCLES(1), .TIMEOUT_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  int errors   = 0;
  int checks   = 0;
  int cyc      = 0;
  int step_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int due; int from_ph; int to_ph;} ev_t;
  logic [3:0] hist[$];
  ev_t        pend[$];
  logic [3:0] m_acc = 4'b0000;
  int m_pos = 0, m_dir = 0, m_err = 0, m_step = 0, m_phase = 0, m_last = 0;
  bit m_seen = 0;

  function automatic int ph_of(input logic [3:0] p);
    case (p)
      4'b0000: return 0;
      4'b1100: return 1;
      4'b0110: return 2;
      4'b0011: return 3;
      4'b1001: return 4;
      default: return 7;
    endcase
  endfunction

  function automatic int wrap14(input int v);
    return (((v + 8192) % 16384) + 16384) % 16384 - 8192;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist.delete(); pend.delete();
      m_acc = 4'b0000; m_pos = 0; m_dir = 0; m_err = 0; m_step = 0; m_phase = 0; m_seen = 0;
    end else begin
      logic [3:0] p;
      bit same, fwd, rev, quiet, set_err;
      ev_t e;
      p = {bus.A1, bus.B1, bus.A2, bus.B2};
      hist.push_back(p);
      if (hist.size() > FILT) void'(hist.pop_front());
      if (hist.size() == FILT && p != m_acc) begin
        same = 1;
        foreach (hist[i]) if (hist[i] != p) same = 0;
        // the last of FILT equal samples shows up on the outputs 4 edges later
        if (same) begin
          pend.push_back('{cyc + 4, ph_of(m_acc), ph_of(p)});
          m_acc = p;
        end
      end
      m_step = 0;
      set_err = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        e = pend.pop_front();
        fwd   = (e.from_ph >= 1 && e.from_ph <= 4 && e.to_ph == e.from_ph % 4 + 1);
        rev   = (e.to_ph >= 1 && e.to_ph <= 4 && e.from_ph == e.to_ph % 4 + 1);
        quiet = (e.to_ph == 0 && e.from_ph != 7) || (e.from_ph == 0 && (e.to_ph == 1 || e.to_ph == 4));
        m_phase = e.to_ph;
        if ((fwd || rev) && !bus.clear) begin
          m_pos  = wrap14(m_pos + (fwd ? 1 : -1));
          m_dir  = fwd ? 1 : 0;
          m_step = 1;
          m_last = cyc;
          m_seen = 1;
        end
        if (!fwd && !rev && !quiet) set_err = 1;
      end
      if (bus.clear) m_pos = 0;
      if (set_err) m_err = 1;
      else if (bus.clear || bus.clear_err) m_err = 0;
    end
  end

  // compare every cycle on the falling edge
  always @(negedge clk) begin
    if (bus.step_pulse) step_cnt++;
    check("model_position", int'(bus.position), m_pos);
    check("model_dir", bus.dir, m_dir);
    check("model_step_pulse", bus.step_pulse, m_step);
    check("model_err", bus.err, m_err);
    check("model_phase", bus.phase, m_phase);
    check("model_moving", bus.moving, (m_seen && (cyc - 1 - m_last) < TMO) ? 1 : 0);
  end

  // ---------------- stimulus ----------------
  task automatic set_pat(input logic [3:0] p);
    {bus.A1, bus.B1, bus.A2, bus.B2} = p;
  endtask

  task automatic hold(input logic [3:0] p, input int n);
    set_pat(p);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive p and pulse clear (sel=1) or clear_err (sel=0) on the edge it is applied
  task automatic pat_with_strobe(input logic [3:0] p, input bit sel);
    set_pat(p);
    repeat (FILT + 3) @(posedge clk);
    #1;
    if (sel) bus.clear = 1'b1; else bus.clear_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  logic [3:0] ring [4];
  int sc0;

  initial begin
    ring[0] = 4'b1100; ring[1] = 4'b0110; ring[2] = 4'b0011; ring[3] = 4'b1001;
    set_pat(4'b0000);
    bus.clear = 1'b0; bus.clear_err = 1'b0;
    {bus2.A1, bus2.B1, bus2.A2, bus2.B2} = 4'b0000;
    bus2.clear = 1'b0; bus2.clear_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_position", int'(bus.position), 0);
    check("rst_phase", bus.phase, 0);
    reset = 1'b1;

    // forward run P1..P1
    sc0 = step_cnt;
    hold(4'b1100, 40); hold(4'b0110, 40); hold(4'b0011, 40); hold(4'b1001, 40); hold(4'b1100, 40);
    check("fwd_steps", step_cnt - sc0, 4);
    check("fwd_position", int'(bus.position), 4);
    check("fwd_dir", bus.dir, 1);
    check("fwd_err", bus.err, 0);

    // reverse run back to P1
    hold(4'b1001, 40); hold(4'b0011, 40); hold(4'b0110, 40); hold(4'b1100, 40);
    check("rev_position", int'(bus.position), 0);
    check("rev_dir", bus.dir, 0);

    // glitches shorter than the filter window
    hold(4'b0110, 40);
    sc0 = step_cnt;
    for (int i = 0; i < 5; i++) begin
      hold(4'b0011, 10);
      hold(4'b0110, 10);
    end
    check("glitch_steps", step_cnt - sc0, 0);
    check("glitch_position", int'(bus.position), 1);
    check("glitch_phase", bus.phase, 2);

    // illegal skip, clear_err, then clear_err colliding with a new illegal skip
    hold(4'b1100, 40);
    hold(4'b0011, 40);
    check("skip_err", bus.err, 1);
    check("skip_position", int'(bus.position), 0);
    check("skip_phase", bus.phase, 3);
    bus.clear_err = 1'b1;
    @(posedge clk); #1;
    bus.clear_err = 1'b0;
    check("clear_err", bus.err, 0);
    hold(4'b0110, 40);
    pat_with_strobe(4'b1001, 1'b0);
    check("err_set_wins", bus.err, 1);
    check("err_set_position", int'(bus.position), -1);
    hold(4'b1001, 20);
    bus.clear_err = 1'b1;
    @(posedge clk); #1;
    bus.clear_err = 1'b0;

    // motion timeout
    hold(4'b1001, 250);
    check("idle_moving", bus.moving, 0);
    set_pat(4'b1100);
    repeat (FILT + 4) @(posedge clk);
    #1;
    check("count_step", bus.step_pulse, 1);
    check("count_moving", bus.moving, 1);
    repeat (TMO - 1) @(posedge clk);
    #1;
    check("moving_last", bus.moving, 1);
    @(posedge clk); #1;
    check("moving_timeout", bus.moving, 0);

    // clear on the counting edge
    hold(4'b0110, 40);
    check("pre_clear_position", int'(bus.position), 1);
    pat_with_strobe(4'b0011, 1'b1);
    check("clear_position", int'(bus.position), 0);
    check("clear_no_step", bus.step_pulse, 0);
    check("clear_dir", bus.dir, 1);
    check("clear_phase", bus.phase, 3);
    hold(4'b0011, 20);

    // reset in the middle of a filter window
    set_pat(4'b1001);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_position", int'(bus.position), 0);
    check("midrst_dir", bus.dir, 0);
    check("midrst_moving", bus.moving, 0);
    check("midrst_phase", bus.phase, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (FILT + 3) @(posedge clk);
    #1;
    check("refilter_before", bus.phase, 0);
    @(posedge clk); #1;
    check("refilter_after", bus.phase, 4);
    hold(4'b1001, 10);

    // wrap check on the single-clock-filter instance
    {bus2.A1, bus2.B1, bus2.A2, bus2.B2} = ring[0];
    for (int i = 1; i <= 8192; i++) begin
      @(posedge clk); #1;
      {bus2.A1, bus2.B1, bus2.A2, bus2.B2} = ring[i % 4];
    end
    repeat (6) @(posedge clk);
    #1;
    check("wrap_fwd", int'(bus2.position), -8192);
    {bus2.A1, bus2.B1, bus2.A2, bus2.B2} = ring[3];
    repeat (6) @(posedge clk);
    #1;
    check("wrap_rev", int'(bus2.position), 8191);
    check("wrap_dir", bus2.dir, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_phase_decoder.md
STEPPER_PHASE_DECODER -- requirements
Module: stepper_phase_decoder

Interface
REQ-001 Parameter FILT_CYCLES, default 16: consecutive clocks a new coil pattern must hold before it is accepted (legal range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576: clocks without an accepted phase change before the block reports motion stopped.
REQ-003 Port clk  input  1: the single clock; all state is on its rising edge.
REQ-004 Port reset  input  1: reset, asynchronous and active-low.
REQ-005 Ports A1, B1, A2, B2  input  1 each: coil drive lines, asynchronous to clk; pattern = {A1,B1,A2,B2}.
REQ-006 Port clear  input  1: synchronous; zeroes position and err.
REQ-007 Port clear_err  input  1: synchronous; zeroes err only.
REQ-008 Port position  output  14 signed: accumulated phase count.
REQ-009 Port dir  output  1: direction of the last counted transition (1 = forward).
REQ-010 Port moving  output  1: a counted transition occurred within the last TIMEOUT_CYCLES clocks.
REQ-011 Port step_pulse  output  1: one-clock pulse per counted transition.
REQ-012 Port err  output  1: sticky illegal-sequence flag.
REQ-013 Port phase  output  3: current accepted phase code.

Function
REQ-014 Each coil line SHALL pass through a 2-flop synchronizer before any other use.
REQ-015 A synchronized pattern differing from the accepted pattern SHALL be accepted only after it holds for FILT_CYCLES consecutive clocks; any change restarts the count.
REQ-016 Pattern decode: 0000=IDLE(0), 1100=P1(1), 0110=P2(2), 0011=P3(3), 1001=P4(4); any other pattern = BAD(7).
REQ-017 Forward transitions P1->P2, P2->P3, P3->P4, P4->P1 SHALL add 1 to position, set dir=1 and pulse step_pulse.
REQ-018 Reverse transitions P4->P3, P3->P2, P2->P1, P1->P4 SHALL subtract 1, set dir=0 and pulse step_pulse.
REQ-019 IDLE->P1, IDLE->P4 and Px->IDLE SHALL be legal and SHALL NOT count.
REQ-020 IDLE->P2, IDLE->P3, P1<->P3, P2<->P4, and any transition to or from BAD SHALL set err and SHALL NOT count; the new pattern is still accepted.
REQ-021 position SHALL wrap modulo 2^14 in two's complement (8191+1 -> -8192; -8192-1 -> 8191).
REQ-022 step_pulse SHALL assert exactly FILT_CYCLES+3 clocks after the clk edge that first samples the new pattern on the coil pins; position, dir and phase update on that same edge.
REQ-023 moving SHALL assert on the edge that pulses step_pulse and SHALL deassert once TIMEOUT_CYCLES clocks pass with no further count; each count restarts the timeout counter.
REQ-024 clear SHALL win over a simultaneous count: position is 0 on the next edge, no step_pulse, dir unchanged.
REQ-025 clear_err coinciding with a new illegal transition SHALL leave err=1 (set wins).
REQ-026 Timeout and filter counters SHALL saturate and never wrap.

Reset
REQ-027 Reset low SHALL immediately force position=0, dir=0, moving=0, step_pulse=0, err=0, phase=IDLE, and clear the synchronizers, filter counter and timeout counter.
REQ-028 Reset asserted mid-filter SHALL discard the pending pattern; after release the block SHALL require a full FILT_CYCLES of stability again.
REQ-029 After reset release the accepted pattern SHALL be IDLE, so a first stable P2 or P3 sets err.

Structure
REQ-030 Package stepper_pkg SHALL hold the phase enum (IDLE, P1..P4, BAD), the five coil pattern constants and the 14-bit position width, shared with the motor driver.
REQ-031 Synchronization and stability filtering SHALL be one sub-module, phase_filter (pattern in, accepted pattern plus one-clock accept strobe out); the top holds the transition decode, counters and flags.

Verification
REQ-032 Reset, then drive P1,P2,P3,P4,P1, each held 40 clocks (FILT_CYCLES=16) -> 4 step_pulses, position=4, dir=1, err=0.
REQ-033 From P1, drive P4,P3,P2,P1 -> position decrements by 4, dir=0; starting at position=-8192, one reverse step -> 8191.
REQ-034 From stable P2, apply 10-clock P3 glitches repeatedly -> no step_pulse, position and phase unchanged.
REQ-035 From P1 drive P3 -> err=1, no count; clear_err -> err=0; a simultaneous clear_err and P2->P4 -> err stays 1.
REQ-036 One forward step, then hold -> moving=1 until TIMEOUT_CYCLES clocks elapse, then 0; clear asserted on the edge of a count -> position=0 and no step_pulse.
REQ-037 Assert reset 8 clocks into a 16-clock filter window -> outputs at reset values at once; the pattern needs a fresh 16 stable clocks after release.
